trig_cfg_fifo: RTL and testbench
================================

TRIG_CFG_FIFO -- requirements
Module: trig_cfg_fifo

Interface
REQ-001 Parameter DATA_W, default 18, entry width ({2-bit stage index, 16-bit config word}).
REQ-002 Parameter ADDR_W, default 4, log2 of depth (16 entries).
REQ-003 Reset usb_rst, asynchronous, active-high; clock usb_clk.
REQ-004 usb_clk  in  1  write-domain clock.
REQ-005 usb_rst  in  1  write-domain reset, async assert, active-high.
REQ-006 core_clk  in  1  read-domain clock, asynchronous to usb_clk.
REQ-007 core_rst  in  1  read-domain reset, async assert, active-high.
REQ-008 din  in  DATA_W  write data, sampled on usb_clk when wr_en=1.
REQ-009 wr_en  in  1  write request (usb_clk domain).
REQ-010 full  out  1  no free entry (usb_clk domain).
REQ-011 rd_en  in  1  pop request (core_clk domain).
REQ-012 dout  out  DATA_W  head entry, valid whenever empty=0 (first-word-fall-through).
REQ-013 empty  out  1  no valid head (core_clk domain).

Function
REQ-014 SHALL be an asynchronous dual-clock FIFO of 2^ADDR_W entries, strict in-order delivery, no data loss or duplication.
REQ-015 Write: on usb_clk rising edge with wr_en=1 and full=0, din SHALL be stored and the write pointer advanced; wr_en while full=1 SHALL be ignored (no overwrite).
REQ-016 Read: FWFT; while empty=0 dout SHALL hold the oldest entry; on core_clk rising edge with rd_en=1 and empty=0 that entry SHALL be consumed and dout SHALL present the next entry (or empty SHALL go 1) after that edge.
REQ-017 rd_en while empty=1 SHALL be ignored; rd_en tied to ~empty SHALL pop exactly one entry per core_clk cycle with dout/empty=0 pairing each entry once.
REQ-018 Pointers ADDR_W+1 bits, binary internally, Gray-coded when crossing domains, each crossing through a 2-flop synchronizer.
REQ-019 full SHALL be registered, computed from write pointer vs synchronized read pointer (MSB/next-MSB inverted Gray compare); may stay asserted conservatively up to 3 usb_clk cycles after a read.
REQ-020 empty SHALL be registered; after a write into an empty FIFO, empty SHALL fall no later than the 4th core_clk rising edge following the write edge (given core_clk not slower than usb_clk/2 by >2x margin irrelevant; bound is in core_clk edges).
REQ-021 empty SHALL never fall before the written data is stable on dout.
REQ-022 Simultaneous write and read in their domains SHALL be legal at any fill level including 0 and 2^ADDR_W-1.
REQ-023 Pointer wrap-around SHALL be seamless across arbitrary numbers of fill/drain cycles.
REQ-024 Storage: dual-port array, written on usb_clk, read address from core_clk domain; output register/prefetch as required for FWFT.

Reset
REQ-025 usb_rst SHALL clear write pointer, its Gray copy and the read-pointer synchronizer; full=0 during and after reset.
REQ-026 core_rst SHALL clear read pointer, its Gray copy, the write-pointer synchronizer and output stage; empty=1, dout=0.
REQ-027 Both resets SHALL be asserted together by the system; contents after reset are don't-care and never presented.
REQ-028 Reset deassertion mid-traffic: writes before the first usb_clk edge after usb_rst release are ignored.

Structure
REQ-029 Shared package: DATA_W, ADDR_W defaults and a bin-to-Gray function.
REQ-030 One sub-module natural: sync_2ff (parameterised-width two-flop synchronizer), instantiated twice.

Verification
REQ-031 Single write din=18'h2_A5A5 into empty FIFO -> within 4 core_clk edges empty=0, dout=18'h2_A5A5; rd_en=1 one cycle -> empty=1.
REQ-032 Burst of 16 writes 18'h0_0000..18'h0_000F with rd_en=0 -> full=1 after 16th; 17th write 18'h3_FFFF ignored; drain returns 0..F in order, never 3_FFFF.
REQ-033 rd_en tied to ~empty, 100 random writes, usb_clk 48 MHz / core_clk 100 MHz and again 100/30 MHz -> identical ordered sequence, no duplicates.
REQ-034 rd_en=1 while empty=1 for 10 cycles, then one write 18'h1_1234 -> exactly one pop of 1_1234.
REQ-035 Reset after 5 writes undrained (both resets pulsed) -> empty=1, full=0, dout=0; subsequent write 18'h0_00C3 is first value read.
REQ-036 300 writes with continuous draining -> pointer wrap; all data in order, full never asserted.

Source files
------------

// File: rtl/trig_cfg_fifo_pkg.sv
// Shared definitions for the trigger-configuration CDC FIFO.
// Default geometry plus the binary-to-Gray helper used on both pointer crossings.
package trig_cfg_fifo_pkg;

    localparam int DATA_W_DEF = 18;
    localparam int ADDR_W_DEF = 4;

    // Fixed 32-bit working width; callers size-cast to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/trig_cfg_fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus; only one bit may change per source update.
// Reset is asynchronous, active-high, in the destination clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trig_cfg_fifo.sv
// Dual-clock first-word-fall-through FIFO carrying stage/config words from usb_clk to core_clk.
// Gray pointers cross through sync_2ff; full and empty are both registered.
module trig_cfg_fifo
    import trig_cfg_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              usb_clk,
    input  logic              usb_rst,
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty
);

    localparam int PW = ADDR_W + 1;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [PW-1:0] wr_bin, wr_gray, wr_bin_nxt, wr_gray_nxt, rd_gray_sync;
    logic [PW-1:0] rd_bin, rd_gray, rd_bin_nxt, rd_gray_nxt, wr_gray_sync;
    logic          wr_push, full_nxt;
    logic          rd_pop, empty_nxt;

    // Write domain
    assign wr_push     = wr_en & ~full;
    assign wr_bin_nxt  = wr_bin + PW'(wr_push);
    assign wr_gray_nxt = PW'(bin2gray(32'(wr_bin_nxt)));
    assign full_nxt    = (wr_gray_nxt == {~rd_gray_sync[PW-1:PW-2], rd_gray_sync[PW-3:0]});

    always_ff @(posedge usb_clk) begin
        if (wr_push) begin
            mem[wr_bin[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            wr_bin  <= '0;
            wr_gray <= '0;
            full    <= 1'b0;
        end else begin
            wr_bin  <= wr_bin_nxt;
            wr_gray <= wr_gray_nxt;
            full    <= full_nxt;
        end
    end

    sync_2ff #(.WIDTH(PW)) u_sync_rd2wr (
        .clk (usb_clk),
        .rst (usb_rst),
        .d   (rd_gray),
        .q   (rd_gray_sync)
    );

    sync_2ff #(.WIDTH(PW)) u_sync_wr2rd (
        .clk (core_clk),
        .rst (core_rst),
        .d   (wr_gray),
        .q   (wr_gray_sync)
    );

    // Read domain: dout is prefetched from the post-pop address so it is valid with empty=0
    assign rd_pop      = rd_en & ~empty;
    assign rd_bin_nxt  = rd_bin + PW'(rd_pop);
    assign rd_gray_nxt = PW'(bin2gray(32'(rd_bin_nxt)));
    assign empty_nxt   = (rd_gray_nxt == wr_gray_sync);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            rd_bin  <= '0;
            rd_gray <= '0;
            empty   <= 1'b1;
            dout    <= '0;
        end else begin
            rd_bin  <= rd_bin_nxt;
            rd_gray <= rd_gray_nxt;
            empty   <= empty_nxt;
            dout    <= empty_nxt ? '0 : mem[rd_bin_nxt[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_trig_cfg_fifo.sv
// Directed bench for trig_cfg_fifo: FWFT latency, full/overflow, empty-read, mid-traffic reset
// and ordered streaming at two clock ratios.
`timescale 1ns/1ps
module tb_trig_cfg_fifo;

    localparam int DW = 18;

    logic          usb_clk, core_clk, usb_rst, core_rst;
    logic          wr_en, rd_man, auto_rd, rd_en, full, empty;
    logic [DW-1:0] din, dout;

    realtime usb_half  = 10.417;
    realtime core_half = 5.0;

    int checks   = 0;
    int failures = 0;
    int full_cnt = 0;

    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];

    trig_cfg_fifo dut (
        .usb_clk  (usb_clk),
        .usb_rst  (usb_rst),
        .core_clk (core_clk),
        .core_rst (core_rst),
        .din      (din),
        .wr_en    (wr_en),
        .full     (full),
        .rd_en    (rd_en),
        .dout     (dout),
        .empty    (empty)
    );

    initial begin
        usb_clk = 1'b0;
        forever begin
            #(usb_half);
            usb_clk = ~usb_clk;
        end
    end

    initial begin
        core_clk = 1'b0;
        forever begin
            #(core_half);
            core_clk = ~core_clk;
        end
    end

    assign rd_en = auto_rd ? ~empty : rd_man;

    always @(negedge core_clk) begin
        if (!core_rst && rd_en && !empty) got_q.push_back(dout);
    end

    always @(negedge usb_clk) begin
        if (full) full_cnt = full_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge usb_clk);
        usb_rst = 1'b1;
        core_rst = 1'b1;
        wr_en = 1'b0;
        rd_man = 1'b0;
        auto_rd = 1'b0;
        repeat (3) @(negedge core_clk);
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("FAIL full_during_reset got=%b exp=0", full);
        end
        repeat (3) @(negedge usb_clk);
        usb_rst = 1'b0;
        core_rst = 1'b0;
        repeat (2) @(negedge core_clk);
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        @(negedge usb_clk);
        din = d;
        wr_en = 1'b1;
        @(negedge usb_clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++;
        if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    endtask

    task automatic test_single();
        int base = got_q.size();
        int n = 0;
        @(negedge usb_clk);
        din = 18'h2_A5A5;
        wr_en = 1'b1;
        @(posedge usb_clk);
        fork
            begin
                @(negedge usb_clk);
                wr_en = 1'b0;
            end
        join_none
        do begin
            @(posedge core_clk);
            #1;
            n++;
        end while (empty && n < 8);
        checks++;
        if (empty !== 1'b0 || n > 4) begin
            failures++;
            $display("FAIL single_latency got=%0d edges (empty=%b) exp<=4", n, empty);
        end
        checks++;
        if (dout !== 18'h2_A5A5) begin failures++; $display("FAIL single_dout got=%h exp=2a5a5", dout); end
        @(posedge core_clk);
        #1 rd_man = 1'b1;
        @(posedge core_clk);
        #1 rd_man = 1'b0;
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL single_empty_after_pop got=%b exp=1", empty); end
        checks++;
        if (got_q.size() != base + 1 || got_q[base] !== 18'h2_A5A5) begin
            failures++;
            $display("FAIL single_pop got=%0d pops exp=1 of 2a5a5", got_q.size() - base);
        end
    endtask

    task automatic test_burst();
        int base;
        int errs = 0;
        for (int i = 0; i < 16; i++) write_word(DW'(i));
        checks++;
        if (full !== 1'b1) begin failures++; $display("FAIL burst_full got=%b exp=1", full); end
        write_word(18'h3_FFFF);
        checks++;
        if (full !== 1'b1) begin failures++; $display("FAIL burst_full_hold got=%b exp=1", full); end
        repeat (6) @(negedge core_clk);
        base = got_q.size();
        @(posedge core_clk);
        #1 auto_rd = 1'b1;
        for (int k = 0; k < 200 && got_q.size() < base + 16; k++) @(negedge core_clk);
        repeat (10) @(negedge core_clk);
        @(posedge core_clk);
        #1 auto_rd = 1'b0;
        checks++;
        if (got_q.size() != base + 16) begin
            failures++;
            $display("FAIL burst_count got=%0d exp=16", got_q.size() - base);
        end
        for (int i = 0; i < 16 && base + i < got_q.size(); i++) begin
            if (got_q[base+i] !== DW'(i)) errs++;
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL burst_order got=%0d wrong entries exp=0", errs); end
        repeat (5) @(negedge usb_clk);
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL burst_full_clear got=%b exp=0", full); end
    endtask

    task automatic test_empty_read();
        int base = got_q.size();
        @(posedge core_clk);
        #1 rd_man = 1'b1;
        repeat (10) @(posedge core_clk);
        checks++;
        if (got_q.size() != base || empty !== 1'b1) begin
            failures++;
            $display("FAIL empty_read_ignored got=%0d pops empty=%b exp=0 pops empty=1", got_q.size() - base, empty);
        end
        write_word(18'h1_1234);
        repeat (12) @(posedge core_clk);
        #1 rd_man = 1'b0;
        checks++;
        if (got_q.size() != base + 1 || got_q[base] !== 18'h1_1234) begin
            failures++;
            $display("FAIL empty_read_single got=%0d pops exp=1 of 11234", got_q.size() - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        for (int i = 0; i < 5; i++) write_word(18'h2_0000 + DW'(i));
        repeat (6) @(negedge core_clk);
        checks++;
        if (empty !== 1'b0) begin failures++; $display("FAIL midrst_pre_empty got=%b exp=0", empty); end
        do_reset();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== '0) begin
            failures++;
            $display("FAIL midrst_state got=empty %b full %b dout %h exp=1 0 0", empty, full, dout);
        end
        base = got_q.size();
        write_word(18'h0_00C3);
        @(posedge core_clk);
        #1 auto_rd = 1'b1;
        for (int k = 0; k < 50 && got_q.size() <= base; k++) @(negedge core_clk);
        repeat (10) @(negedge core_clk);
        @(posedge core_clk);
        #1 auto_rd = 1'b0;
        checks++;
        if (got_q.size() != base + 1 || got_q[base] !== 18'h0_00C3) begin
            failures++;
            $display("FAIL midrst_first got=%0d pops exp=1 of 000c3", got_q.size() - base);
        end
    endtask

    task automatic test_stream(input int n, input bit gaps, input bit no_full, input string name);
        int base = got_q.size();
        int fc0 = full_cnt;
        int errs = 0;
        int i = 0;
        exp_q.delete();
        @(posedge core_clk);
        #1 auto_rd = 1'b1;
        while (i < n) begin
            @(negedge usb_clk);
            if (!full && (!gaps || $urandom_range(0, 3) != 0)) begin
                din = DW'($urandom);
                wr_en = 1'b1;
                exp_q.push_back(din);
                i++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge usb_clk);
        wr_en = 1'b0;
        for (int k = 0; k < 5000 && got_q.size() < base + n; k++) @(negedge core_clk);
        repeat (10) @(negedge core_clk);
        @(posedge core_clk);
        #1 auto_rd = 1'b0;
        checks++;
        if (got_q.size() != base + n) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size() - base, n);
        end
        for (int j = 0; j < n && base + j < got_q.size(); j++) begin
            if (got_q[base+j] !== exp_q[j]) errs++;
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL %s_order got=%0d wrong entries exp=0", name, errs); end
        if (no_full) begin
            checks++;
            if (full_cnt != fc0) begin
                failures++;
                $display("FAIL %s_full_seen got=%0d cycles exp=0", name, full_cnt - fc0);
            end
        end
    endtask

    initial begin
        usb_rst = 1'b1;
        core_rst = 1'b1;
        wr_en = 1'b0;
        rd_man = 1'b0;
        auto_rd = 1'b0;
        din = '0;
        #50;
        test_reset();
        test_single();
        test_burst();
        test_empty_read();
        test_reset_mid();
        test_stream(100, 1'b1, 1'b0, "stream_48_100");
        test_stream(300, 1'b0, 1'b1, "wrap_300");
        usb_half = 5.0;
        core_half = 16.667;
        repeat (4) @(negedge core_clk);
        test_stream(100, 1'b1, 1'b0, "stream_100_30");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
